icache_fill_fsm: RTL and testbench
==================================

Name: icache_fill_fsm

Overview:
- Responder side of the instruction-fetch path. The PC register issues fetch addresses. On an I-cache miss for that address, this block fetches the whole 16-byte block from multicycle main memory and writes it into the I-cache data and tag arrays.
- It stalls fetch with fill_busy for the whole fill. The PC register holds its value while fill_busy is high.

Parameters:
- WORDS_PER_BLOCK, 8: 16-bit words per cache block. Fixed at 8 so the word index is 3 bits.
- MEM_LATENCY, 4: cycles from a request with mem_en high to the matching mem_data_valid. Used by the bench memory model only; the RTL counts valid pulses, not cycles.

Ports:
- clk  in  1  system clock, all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- pc_addr  in  16  fetch address from the PC register; bit 0 ignored.
- miss_detected  in  1  I-cache tag mismatch or invalid line for pc_addr.
- fill_busy  out  1  fetch stall; PC must hold while this is high.
- mem_en  out  1  memory read request, one word per cycle.
- mem_addr  out  16  word address of the current request.
- mem_data_in  in  16  returned memory word.
- mem_data_valid  in  1  mem_data_in is valid this cycle; responses arrive in request order.
- cache_data_we  out  1  write mem_data_in into the data array.
- cache_word_idx  out  3  word slot within the block for the data write.
- cache_write_data  out  16  equals mem_data_in.
- cache_tag_we  out  1  write tag = base[15:4] and set valid; pulsed with the final word.
- fill_done  out  1  one-cycle pulse when a fill completes.

Behaviour:
- Reset (rst_n low at posedge):
  - state goes to IDLE; req_cnt and rcv_cnt go to 0; base goes to 0.
  - All outputs are 0 from the next cycle on: fill_busy, mem_en, mem_addr, cache_data_we, cache_word_idx, cache_tag_we, fill_done.
  - Reset mid-fill abandons the fill. No further array writes occur. The tag is not written, so the line stays invalid.
- States: IDLE, FILL, DONE.
- IDLE:
  - fill_busy = miss_detected (combinational), so the stall is seen in the same cycle as the miss.
  - mem_data_valid is ignored.
  - On a posedge with miss_detected high: latch base = {pc_addr[15:4], 4'h0}, clear both counters, go to FILL.
- FILL:
  - fill_busy = 1.
  - Requests: while req_cnt < 8, drive mem_en = 1 and mem_addr = base + 2*req_cnt, then increment req_cnt. This gives exactly 8 requests on consecutive cycles.
  - Responses:
    - Each cycle with mem_data_valid high: cache_data_we = 1, cache_word_idx = rcv_cnt[2:0], then increment rcv_cnt.
    - Responses may overlap with requests still being issued.
  - When mem_data_valid is high and rcv_cnt == 7: cache_tag_we = 1 in the same cycle, and the next state is DONE.
  - mem_data_valid with rcv_cnt == 8 cannot occur; if it does, ignore it with no write.
  - miss_detected is ignored in FILL.
- DONE:
  - fill_busy = 1 and fill_done = 1 for exactly one cycle, then go to IDLE.
  - In IDLE the pipeline re-looks-up and now hits. A fresh miss_detected in IDLE starts a new fill.
- Address arithmetic:
  - 16-bit. A block fits inside one aligned 16-byte region, so base + 14 never carries out.
  - base 0xFFF0 gives requests 0xFFF0 through 0xFFFE.
- Timing with MEM_LATENCY = 4: 1 IDLE miss cycle + 12 FILL cycles + 1 DONE cycle = 14 cycles of fill_busy per miss.

Optional Feature:
- Macro: ICACHE_CRITICAL_WORD_FIRST_EN.
- Defined:
  - Latch start = pc_addr[3:1] together with base.
  - Request k uses mem_addr = base + 2*((start + k) mod 8).
  - Response k writes cache_word_idx = (start + k) mod 8.
  - Added output crit_word_valid (1 bit) pulses with response k = 0, so the pipeline may consume the requested word early. fill_busy behaviour is unchanged.
- Undefined: start = 0 and the crit_word_valid port is absent.

Test Plan:
- Reset: hold rst_n = 0 for 20 cycles with miss_detected = 1 -> all outputs 0. After release, fill_busy = 1 combinationally and state FILL after the next posedge.
- Basic fill: pc_addr = 0x0126, miss pulse, memory returns addr ^ 0xA5A5 -> mem_addr 0x0120 through 0x012E on 8 consecutive cycles, words written at idx 0–7, cache_tag_we with idx 7, fill_done once, fill_busy high for exactly 14 cycles.
- Top-of-memory: pc_addr = 0xFFFE -> requests 0xFFF0 through 0xFFFE, no address wrap to 0x0000.
- Reset mid-fill: drop rst_n after the 3rd data write -> no further cache_data_we or cache_tag_we, IDLE, fill_busy = 0 the next cycle.
- Back-to-back misses: second miss asserted in the cycle right after fill_done -> a new fill starts with base from the new pc_addr. miss_detected held during FILL does not restart the counters.
- With ICACHE_CRITICAL_WORD_FIRST_EN: pc_addr = 0x013A -> request order 0x013A, 0x013C, 0x013E, 0x0130, …, 0x0138, write idx order 5,6,7,0,…,4, crit_word_valid with the first response.

Source files
------------

// File: rtl/icache_fill_if.sv
// icache_fill_if: fetch-side and memory-side signals of the I-cache fill engine.
// Optional port crit_word_valid exists only when ICACHE_CRITICAL_WORD_FIRST_EN is defined.
interface icache_fill_if;
  logic [15:0] pc_addr;
  logic        miss_detected;
  logic        fill_busy;
  logic        mem_en;
  logic [15:0] mem_addr;
  logic [15:0] mem_data_in;
  logic        mem_data_valid;
  logic        cache_data_we;
  logic [2:0]  cache_word_idx;
  logic [15:0] cache_write_data;
  logic        cache_tag_we;
  logic        fill_done;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  logic        crit_word_valid;
`endif

  // Fill engine side: sees the fetch address and memory responses.
  modport slave (
    input  pc_addr, miss_detected, mem_data_in, mem_data_valid,
    output fill_busy, mem_en, mem_addr, cache_data_we, cache_word_idx,
           cache_write_data, cache_tag_we, fill_done
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    , output crit_word_valid
`endif
  );

  // Pipeline / memory side.
  modport master (
    output pc_addr, miss_detected, mem_data_in, mem_data_valid,
    input  fill_busy, mem_en, mem_addr, cache_data_we, cache_word_idx,
           cache_write_data, cache_tag_we, fill_done
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    , input crit_word_valid
`endif
  );
endinterface

// File: rtl/icache_fill_fsm.sv
// icache_fill_fsm: on an I-cache miss, reads the 8-word block from main memory,
// writes each word into the data array and the tag with the last word.
// Optional feature macro: ICACHE_CRITICAL_WORD_FIRST_EN (wrap-around fill starting
// at the missed word, plus crit_word_valid pulse on the first response).
module icache_fill_fsm (
  input  logic         clk,
  input  logic         rst_n,
  icache_fill_if.slave bus
);
  localparam int unsigned WORDS_PER_BLOCK = 8;
  localparam logic [3:0]  ALL_WORDS       = 4'(WORDS_PER_BLOCK);
  localparam logic [3:0]  LAST_WORD       = 4'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_e;

  state_e      state_q, state_d;
  logic [3:0]  req_cnt_q, req_cnt_d;
  logic [3:0]  rcv_cnt_q, rcv_cnt_d;
  logic [15:4] base_q, base_d;   // block base; low nibble is always zero
  logic [2:0]  start_w;          // first word of the fill order

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  logic [2:0] start_q, start_d;
  logic       unused_pc_bit;
  assign start_w       = start_q;
  assign unused_pc_bit = bus.pc_addr[0];
`else
  logic unused_pc_bits;
  assign start_w        = 3'd0;
  assign unused_pc_bits = ^bus.pc_addr[3:0];
`endif

  logic        fill_busy, mem_en, data_we, tag_we, fill_done, crit;
  logic [15:0] mem_addr;
  logic [2:0]  word_idx;
  logic [2:0]  req_word;
  logic        rsp_accept;

  assign req_word   = start_w + req_cnt_q[2:0];
  assign rsp_accept = bus.mem_data_valid && (rcv_cnt_q < ALL_WORDS);

  // State register with synchronous active-low reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      req_cnt_q <= '0;
      rcv_cnt_q <= '0;
      base_q    <= '0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      start_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      rcv_cnt_q <= rcv_cnt_d;
      base_q    <= base_d;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      start_q   <= start_d;
`endif
    end
  end

  // Next-state and counter update.
  // NOTE: every comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d   = state_q;
    req_cnt_d = req_cnt_q;
    rcv_cnt_d = rcv_cnt_q;
    base_d    = base_q;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    start_d   = start_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.miss_detected) begin
          state_d   = FILL;
          base_d    = bus.pc_addr[15:4];
          req_cnt_d = '0;
          rcv_cnt_d = '0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
          start_d   = bus.pc_addr[3:1];
`endif
        end
      end
      FILL: begin
        if (req_cnt_q < ALL_WORDS) req_cnt_d = req_cnt_q + 4'd1;
        if (rsp_accept) begin
          rcv_cnt_d = rcv_cnt_q + 4'd1;
          if (rcv_cnt_q == LAST_WORD) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode; everything is forced low while reset is asserted.
  always_comb begin
    fill_busy = 1'b0;
    mem_en    = 1'b0;
    mem_addr  = '0;
    data_we   = 1'b0;
    word_idx  = '0;
    tag_we    = 1'b0;
    fill_done = 1'b0;
    crit      = 1'b0;
    unique case (state_q)
      IDLE: fill_busy = bus.miss_detected;
      FILL: begin
        fill_busy = 1'b1;
        if (req_cnt_q < ALL_WORDS) begin
          mem_en   = 1'b1;
          // Block is 16-byte aligned, so the word offset never carries into the tag.
          mem_addr = {base_q, req_word, 1'b0};
        end
        if (rsp_accept) begin
          data_we  = 1'b1;
          word_idx = start_w + rcv_cnt_q[2:0];
          tag_we   = (rcv_cnt_q == LAST_WORD);
          crit     = (rcv_cnt_q == 4'd0);
        end
      end
      DONE: begin
        fill_busy = 1'b1;
        fill_done = 1'b1;
      end
      default: fill_busy = 1'b0;
    endcase
    if (!rst_n) begin
      fill_busy = 1'b0;
      mem_en    = 1'b0;
      mem_addr  = '0;
      data_we   = 1'b0;
      word_idx  = '0;
      tag_we    = 1'b0;
      fill_done = 1'b0;
      crit      = 1'b0;
    end
  end

  assign bus.fill_busy        = fill_busy;
  assign bus.mem_en           = mem_en;
  assign bus.mem_addr         = mem_addr;
  assign bus.cache_data_we    = data_we;
  assign bus.cache_word_idx   = word_idx;
  assign bus.cache_write_data = bus.mem_data_in;
  assign bus.cache_tag_we     = tag_we;
  assign bus.fill_done        = fill_done;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
  assign bus.crit_word_valid  = crit;
`else
  logic unused_crit;
  assign unused_crit = crit;
`endif
endmodule

// File: tb/tb_icache_fill_fsm.sv
// tb_icache_fill_fsm: randomized fills against a fixed-latency memory model, with a
// block-level reference model feeding scoreboard queues checked by a negedge monitor.
module tb_icache_fill_fsm;
  localparam int MEM_LATENCY = 4;
  localparam int WORDS       = 8;
  localparam int FILL_BUSY   = 1 + (WORDS - 1 + MEM_LATENCY + 1) + 1;

  typedef struct {
    logic [2:0]  idx;
    logic [15:0] data;
    logic        last;
    logic        first;
  } wr_t;

  typedef struct {
    int          due;
    logic [15:0] addr;
  } pend_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  icache_fill_if bus_if ();

  icache_fill_fsm dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  logic [15:0] exp_req[$];
  wr_t         exp_wr[$];
  logic [15:0] exp_done[$];
  int          exp_busy[$];
  pend_t       pend[$];

  int checks = 0;
  int errors = 0;
  int wr_seen = 0;
  int done_seen = 0;
  int cyc = 0;
  int busy_run = 0;
  bit stray_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] addr);
    return addr ^ 16'hA5A5;
  endfunction

  // Reference model: block fill order and contents from the block base and start word.
  function automatic void model_fill(input logic [15:0] pc, input int n_req, input int n_wr,
                                     input bit complete);
    logic [15:0] base;
    logic [2:0]  start;
    logic [2:0]  w;
    logic [15:0] a;
    base = pc & 16'hFFF0;
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    start = pc[3:1];
`else
    start = 3'd0;
`endif
    for (int k = 0; k < n_req; k++) begin
      w = 3'((int'(start) + k) % WORDS);
      exp_req.push_back(base + 16'(2 * int'(w)));
    end
    for (int k = 0; k < n_wr; k++) begin
      w = 3'((int'(start) + k) % WORDS);
      a = base + 16'(2 * int'(w));
      exp_wr.push_back('{idx: w, data: mem_word(a), last: (k == WORDS - 1), first: (k == 0)});
    end
    if (complete) exp_done.push_back(base);
  endfunction

  // Memory model: fixed latency, in-order, optional stray valid pulses.
  always @(posedge clk) begin
    pend_t p;
    #2;
    cyc++;
    bus_if.mem_data_valid = 1'b0;
    bus_if.mem_data_in    = 16'($urandom);
    if (pend.size() > 0 && pend[0].due == cyc) begin
      p = pend.pop_front();
      bus_if.mem_data_valid = 1'b1;
      bus_if.mem_data_in    = mem_word(p.addr);
    end else if (stray_en) begin
      bus_if.mem_data_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (!rst_n) pend.delete();
    else if (bus_if.mem_en) pend.push_back('{due: cyc + MEM_LATENCY, addr: bus_if.mem_addr});
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    wr_t e;
    if (bus_if.fill_busy) busy_run++;
    else if (busy_run > 0) begin
      check("busy_run_expected", 32'(exp_busy.size() != 0), 32'd1);
      if (exp_busy.size() != 0) check("fill_busy_cycles", 32'(busy_run), 32'(exp_busy.pop_front()));
      busy_run = 0;
    end
    if (!rst_n) begin
      check("reset_outputs", {8'h0, bus_if.fill_busy, bus_if.mem_en, bus_if.mem_addr,
            bus_if.cache_data_we, bus_if.cache_word_idx, bus_if.cache_tag_we, bus_if.fill_done}, 32'd0);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
      check("reset_crit", 32'(bus_if.crit_word_valid), 32'd0);
`endif
    end else begin
      if (bus_if.mem_en) begin
        check("req_expected", 32'(exp_req.size() != 0), 32'd1);
        if (exp_req.size() != 0) check("mem_addr", 32'(bus_if.mem_addr), 32'(exp_req.pop_front()));
      end
      if (bus_if.cache_data_we) begin
        wr_seen++;
        check("write_expected", 32'(exp_wr.size() != 0), 32'd1);
        if (exp_wr.size() != 0) begin
          e = exp_wr.pop_front();
          check("cache_word_idx", 32'(bus_if.cache_word_idx), 32'(e.idx));
          check("cache_write_data", 32'(bus_if.cache_write_data), 32'(e.data));
          check("cache_tag_we", 32'(bus_if.cache_tag_we), 32'(e.last));
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
          check("crit_word_valid", 32'(bus_if.crit_word_valid), 32'(e.first));
`endif
        end
      end else begin
        check("tag_we_without_write", 32'(bus_if.cache_tag_we), 32'd0);
`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
        check("crit_without_write", 32'(bus_if.crit_word_valid), 32'd0);
`endif
      end
      if (bus_if.fill_done) begin
        done_seen++;
        check("done_expected", 32'(exp_done.size() != 0), 32'd1);
        if (exp_done.size() != 0) void'(exp_done.pop_front());
        check("done_after_last_word", 32'(exp_wr.size()), 32'd0);
      end
    end
  end

  // Start a fill: miss for one cycle (or held through FILL).
  task automatic issue_fill(input logic [15:0] pc, input bit hold_miss, input int busy_len);
    @(posedge clk);
    #1;
    bus_if.pc_addr       = pc;
    bus_if.miss_detected = 1'b1;
    model_fill(pc, WORDS, WORDS, 1'b1);
    if (busy_len > 0) exp_busy.push_back(busy_len);
    @(posedge clk);
    #1;
    if (!hold_miss) bus_if.miss_detected = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_seen < target && n < 60) begin
      @(posedge clk);
      n++;
    end
    check("fill_done_within_budget", 32'(done_seen >= target), 32'd1);
    #1;
  endtask

  task automatic idle_gap(input int gap);
    repeat (gap) begin
      stray_en = 1'($urandom);
      @(posedge clk);
      #1;
    end
    stray_en = 1'b0;
  endtask

  initial begin
    int n;
    int w0;
    int d0;
    logic [15:0] pc_a;
    logic [15:0] pc_b;
    bus_if.pc_addr        = 16'h0126;
    bus_if.miss_detected  = 1'b1;
    bus_if.mem_data_in    = 16'h0;
    bus_if.mem_data_valid = 1'b0;

    // Reset held with miss asserted; then release into the basic fill.
    repeat (20) @(posedge clk);
    model_fill(16'h0126, WORDS, WORDS, 1'b1);
    exp_busy.push_back(FILL_BUSY);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("busy_same_cycle_as_miss", 32'(bus_if.fill_busy), 32'd1);
    @(posedge clk);
    #1 bus_if.miss_detected = 1'b0;
    wait_done(1);
    idle_gap(2);

    // Top of memory.
    issue_fill(16'hFFFE, 1'b0, FILL_BUSY);
    wait_done(2);
    idle_gap(1);

`ifdef ICACHE_CRITICAL_WORD_FIRST_EN
    issue_fill(16'h013A, 1'b0, FILL_BUSY);
    wait_done(done_seen + 1);
    idle_gap(1);
`endif

    // Reset after the third data write: seven requests, three writes, no tag.
    w0 = wr_seen;
    @(posedge clk);
    #1;
    bus_if.pc_addr       = 16'h4A52;
    bus_if.miss_detected = 1'b1;
    model_fill(16'h4A52, 2 + MEM_LATENCY + 1, 3, 1'b0);
    exp_busy.push_back(1 + 2 + MEM_LATENCY + 1);
    @(posedge clk);
    #1 bus_if.miss_detected = 1'b0;
    n = 0;
    while (wr_seen < w0 + 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("third_write_within_budget", 32'(wr_seen - w0), 32'd3);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle_after_reset", {30'h0, bus_if.fill_busy, bus_if.mem_en}, 32'd0);
    check("no_write_after_reset", 32'(wr_seen - w0), 32'd3);
    idle_gap(2);

    // Back-to-back: miss held through FILL, new address right after fill_done.
    d0   = done_seen;
    pc_a = 16'h2468;
    pc_b = 16'hBEEC;
    issue_fill(pc_a, 1'b1, 2 * FILL_BUSY);
    n = 0;
    while (done_seen < d0 + 1 && n < 60) begin
      @(posedge clk);
      n++;
    end
    check("first_of_pair_done", 32'(done_seen - d0), 32'd1);
    #1;
    bus_if.pc_addr = pc_b;
    model_fill(pc_b, WORDS, WORDS, 1'b1);
    @(posedge clk);
    #1 bus_if.miss_detected = 1'b0;
    wait_done(d0 + 2);
    idle_gap(3);

    // Randomized fills with random gaps and stray valid pulses while idle.
    for (int i = 0; i < 12; i++) begin
      issue_fill(16'($urandom), 1'b0, FILL_BUSY);
      wait_done(done_seen + 1);
      idle_gap(int'($urandom_range(0, 3)));
    end

    repeat (5) @(posedge clk);
    check("req_queue_drained", 32'(exp_req.size()), 32'd0);
    check("write_queue_drained", 32'(exp_wr.size()), 32'd0);
    check("done_queue_drained", 32'(exp_done.size()), 32'd0);
    check("busy_queue_drained", 32'(exp_busy.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
